cpu_writeback: RTL and testbench

Stage-4 (writeback) block of the stack CPU pipeline; consumes every `_3a` signal registered by the execute stage. Applies pops and pushes to the operand stack and resolves branches. On a taken branch it issues a fetch redirect and drives `kill_4a` back to execute to squash wrong-path work. It also serves the two top-of-stack entries (`st__top_0_2a`, `st__top_1_2a`) to the execute stage.

---
 rtl/cpu_writeback_pkg.sv | 41 ++++
 rtl/cpu_stack_regfile.sv | 42 ++++
 rtl/cpu_writeback.sv | 187 ++++++++++++++++++
 tb/tb_cpu_writeback.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_writeback_pkg.sv
// Shared constants and helpers for the writeback stage and its stack storage.
package cpu_writeback_pkg;

    localparam int unsigned ENTRY_W = 35;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned INSTR_W = 48;
    localparam int unsigned POP_W   = 11;

    // Push codes
    localparam logic [2:0] UC_PUSH_NONE  = 3'd0;
    localparam logic [2:0] UC_PUSH_ALU   = 3'd1;
    localparam logic [2:0] UC_PUSH_IMM   = 3'd2;
    localparam logic [2:0] UC_PUSH_R0    = 3'd3;
    localparam logic [2:0] UC_PUSH_R1    = 3'd4;
    localparam logic [2:0] UC_PUSH_R1_R0 = 3'd5;
    localparam logic [2:0] UC_PUSH_RET   = 3'd6;
    localparam logic [2:0] UC_PUSH_RSVD  = 3'd7;

    // Branch codes
    localparam logic [1:0] UC_BRANCH_NONE   = 2'd0;
    localparam logic [1:0] UC_BRANCH_ALWAYS = 2'd1;
    localparam logic [1:0] UC_BRANCH_COND   = 2'd2;
    localparam logic [1:0] UC_BRANCH_NCOND  = 2'd3;

    // Stack entry: type tag over data word
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } stack_entry_t;

    // Number of entries a push code places on the stack
    function automatic logic [1:0] push_count(input logic [2:0] code);
        case (code)
            UC_PUSH_NONE, UC_PUSH_RSVD: return 2'd0;
            UC_PUSH_R1_R0:              return 2'd2;
            default:                    return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/cpu_stack_regfile.sv
// Operand stack storage: flop array with two write ports and two async read ports.
module cpu_stack_regfile
    import cpu_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               we0,
    input  logic [AW-1:0]      waddr0,
    input  stack_entry_t       wdata0,
    input  logic               we1,
    input  logic [AW-1:0]      waddr1,
    input  stack_entry_t       wdata1,
    input  logic [AW-1:0]      raddr0,
    output stack_entry_t       rdata0_c,
    input  logic [AW-1:0]      raddr1,
    output stack_entry_t       rdata1_c
);

    stack_entry_t mem [DEPTH];

    // Entry storage; the two write addresses are never equal when both enabled
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
        end
    end

    // Read ports return pre-update contents
    always_comb begin
        rdata0_c = mem[raddr0];
        rdata1_c = mem[raddr1];
    end

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: applies stack pops/pushes, detects stack faults, resolves branches.
module cpu_writeback
    import cpu_writeback_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned KILL_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      alu__cond_3a,
    input  logic [DATA_W-1:0]         alu__out_3a,
    input  logic [1:0]                c__branch_3a,
    input  logic [2:0]                c__to_push_3a,
    input  logic [INSTR_W-1:0]        instruction_3a,
    input  logic [DATA_W-1:0]         pc_3a,
    input  logic [ENTRY_W-1:0]        r0_3a,
    input  logic [ENTRY_W-1:0]        r1_3a,
    input  logic [POP_W-1:0]          st__to_pop_3a,
    output logic                      kill_4a,
    output logic                      redirect_valid_4a,
    output logic [DATA_W-1:0]         redirect_pc_4a,
    output logic [ENTRY_W-1:0]        st__top_0_2a,
    output logic [ENTRY_W-1:0]        st__top_1_2a,
    output logic [$clog2(DEPTH):0]    st__depth_4a,
    output logic                      st__fault_4a
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;
    localparam int unsigned CW = ((DW > POP_W) ? DW : POP_W) + 2;
    localparam int unsigned KW = $clog2(KILL_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_KILL = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;

    stack_entry_t  push_a_c, push_b_c;
    stack_entry_t  rdata0_c, rdata1_c;
    logic [1:0]    npush_c;
    logic [CW-1:0] depth_w_c, pop_w_c, base_w_c, nd_w_c;
    logic          active_c, underflow_c, overflow_c, commit_c, fault_now_c;
    logic          br_hit_c, taken_c;
    logic [ENTRY_W-1:0] top0_next_c, top1_next_c;
    logic          unused_c;

    assign unused_c = ^instruction_3a[INSTR_W-1:ENTRY_W];

    // Select pushed entries; for the dual push, push_a goes below push_b
    always_comb begin
        push_a_c = '0;
        push_b_c = '0;
        npush_c  = push_count(c__to_push_3a);
        case (c__to_push_3a)
            UC_PUSH_ALU:   push_a_c = {TAG_W'(0), alu__out_3a};
            UC_PUSH_IMM:   push_a_c = instruction_3a[ENTRY_W-1:0];
            UC_PUSH_R0:    push_a_c = r0_3a;
            UC_PUSH_R1:    push_a_c = r1_3a;
            UC_PUSH_R1_R0: begin
                push_a_c = r1_3a;
                push_b_c = r0_3a;
            end
            UC_PUSH_RET:   push_a_c = {TAG_W'(0), pc_3a + DATA_W'(6)};
            default: ;
        endcase
    end

    // Pointer arithmetic, fault detection and branch resolution
    always_comb begin
        active_c    = !kill_4a && !st__fault_4a;
        depth_w_c   = CW'(st__depth_4a);
        pop_w_c     = CW'(st__to_pop_3a);
        base_w_c    = depth_w_c - pop_w_c;
        nd_w_c      = base_w_c + CW'(npush_c);
        underflow_c = pop_w_c > depth_w_c;
        overflow_c  = !underflow_c && (nd_w_c > CW'(DEPTH));
        fault_now_c = active_c && (underflow_c || overflow_c);
        commit_c    = active_c && !underflow_c && !overflow_c;
        case (c__branch_3a)
            UC_BRANCH_ALWAYS: br_hit_c = 1'b1;
            UC_BRANCH_COND:   br_hit_c = alu__cond_3a;
            UC_BRANCH_NCOND:  br_hit_c = !alu__cond_3a;
            default:          br_hit_c = 1'b0;
        endcase
        taken_c = commit_c && br_hit_c;
    end

    cpu_stack_regfile #(.DEPTH(DEPTH)) u_regfile (
        .clk      (clk),
        .rst_b    (rst_b),
        .we0      (commit_c && (npush_c != 2'd0)),
        .waddr0   (AW'(base_w_c)),
        .wdata0   (push_a_c),
        .we1      (commit_c && (npush_c == 2'd2)),
        .waddr1   (AW'(base_w_c + CW'(1))),
        .wdata1   (push_b_c),
        .raddr0   (AW'(nd_w_c - CW'(1))),
        .rdata0_c (rdata0_c),
        .raddr1   (AW'(nd_w_c - CW'(2))),
        .rdata1_c (rdata1_c)
    );

    // Post-update top entries: freshly pushed values override the old array
    always_comb begin
        top0_next_c = '0;
        top1_next_c = '0;
        if (nd_w_c >= CW'(1)) begin
            case (npush_c)
                2'd2:    top0_next_c = push_b_c;
                2'd1:    top0_next_c = push_a_c;
                default: top0_next_c = rdata0_c;
            endcase
        end
        if (nd_w_c >= CW'(2)) begin
            top1_next_c = (npush_c == 2'd2) ? push_a_c : rdata1_c;
        end
    end

    // Stack state and sticky fault
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            st__depth_4a <= '0;
            st__top_0_2a <= '0;
            st__top_1_2a <= '0;
            st__fault_4a <= 1'b0;
        end else begin
            if (commit_c) begin
                st__depth_4a <= DW'(nd_w_c);
                st__top_0_2a <= top0_next_c;
                st__top_1_2a <= top1_next_c;
            end
            if (fault_now_c) st__fault_4a <= 1'b1;
        end
    end

    // Kill FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Kill FSM next state: load on taken branch, count down to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (taken_c) begin
                    state_d = ST_KILL;
                    cnt_d   = KW'(KILL_CYCLES);
                end
            end
            ST_KILL: begin
                if (cnt_q == KW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - KW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered kill and redirect outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            kill_4a           <= 1'b0;
            redirect_valid_4a <= 1'b0;
            redirect_pc_4a    <= '0;
        end else begin
            kill_4a           <= (cnt_d != '0);
            redirect_valid_4a <= taken_c;
            if (taken_c) redirect_pc_4a <= instruction_3a[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_cpu_writeback.sv
// Directed bench for cpu_writeback with a queue-based stack model checked every cycle.
module tb_cpu_writeback;

    localparam int DEPTH = 8;
    localparam int KC    = 2;
    localparam int DW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_b;
    logic          alu__cond_3a;
    logic [31:0]   alu__out_3a;
    logic [1:0]    c__branch_3a;
    logic [2:0]    c__to_push_3a;
    logic [47:0]   instruction_3a;
    logic [31:0]   pc_3a;
    logic [34:0]   r0_3a;
    logic [34:0]   r1_3a;
    logic [10:0]   st__to_pop_3a;
    logic          kill_4a;
    logic          redirect_valid_4a;
    logic [31:0]   redirect_pc_4a;
    logic [34:0]   st__top_0_2a;
    logic [34:0]   st__top_1_2a;
    logic [DW-1:0] st__depth_4a;
    logic          st__fault_4a;

    cpu_writeback #(.DEPTH(DEPTH), .KILL_CYCLES(KC)) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .alu__cond_3a      (alu__cond_3a),
        .alu__out_3a       (alu__out_3a),
        .c__branch_3a      (c__branch_3a),
        .c__to_push_3a     (c__to_push_3a),
        .instruction_3a    (instruction_3a),
        .pc_3a             (pc_3a),
        .r0_3a             (r0_3a),
        .r1_3a             (r1_3a),
        .st__to_pop_3a     (st__to_pop_3a),
        .kill_4a           (kill_4a),
        .redirect_valid_4a (redirect_valid_4a),
        .redirect_pc_4a    (redirect_pc_4a),
        .st__top_0_2a      (st__top_0_2a),
        .st__top_1_2a      (st__top_1_2a),
        .st__depth_4a      (st__depth_4a),
        .st__fault_4a      (st__fault_4a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [34:0] m_stk[$];
    bit          m_fault = 0;
    int          m_kill  = 0;
    bit          m_rv    = 0;
    logic [31:0] m_rpc   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_fault = 0;
        m_kill  = 0;
        m_rv    = 0;
        m_rpc   = '0;
    endtask

    task automatic model_step();
        logic [34:0] pushes[$];
        int  pop;
        bit  taken;
        pop  = int'(st__to_pop_3a);
        m_rv = 0;
        if (m_kill != 0 || m_fault) begin
            if (m_kill > 0) m_kill--;
            return;
        end
        case (c__to_push_3a)
            3'd1: pushes.push_back({3'b0, alu__out_3a});
            3'd2: pushes.push_back(instruction_3a[34:0]);
            3'd3: pushes.push_back(r0_3a);
            3'd4: pushes.push_back(r1_3a);
            3'd5: begin pushes.push_back(r1_3a); pushes.push_back(r0_3a); end
            3'd6: pushes.push_back({3'b0, pc_3a + 32'd6});
            default: ;
        endcase
        if (pop > m_stk.size() || m_stk.size() - pop + pushes.size() > DEPTH) begin
            m_fault = 1;
            return;
        end
        repeat (pop) void'(m_stk.pop_back());
        foreach (pushes[i]) m_stk.push_back(pushes[i]);
        taken = (c__branch_3a == 2'd1) || (c__branch_3a == 2'd2 && alu__cond_3a)
             || (c__branch_3a == 2'd3 && !alu__cond_3a);
        if (taken) begin
            m_kill = KC;
            m_rv   = 1;
            m_rpc  = instruction_3a[31:0];
        end
    endtask

    task automatic compare_all();
        int n;
        n = m_stk.size();
        chk("depth",  64'(st__depth_4a), 64'(n));
        chk("top0",   64'(st__top_0_2a), (n >= 1) ? 64'(m_stk[n-1]) : 64'd0);
        chk("top1",   64'(st__top_1_2a), (n >= 2) ? 64'(m_stk[n-2]) : 64'd0);
        chk("kill",   64'(kill_4a), 64'(m_kill != 0));
        chk("rvalid", 64'(redirect_valid_4a), 64'(m_rv));
        chk("rpc",    64'(redirect_pc_4a), 64'(m_rpc));
        chk("fault",  64'(st__fault_4a), 64'(m_fault));
    endtask

    // Model advance and per-cycle comparison
    always @(posedge clk) begin
        if (rst_b) model_step();
        else       model_reset();
        #1;
        compare_all();
    end

    always @(negedge rst_b) model_reset();

    task automatic op(input logic [2:0] push, input logic [10:0] pop,
                      input logic [1:0] br, input logic cond);
        c__to_push_3a = push;
        st__to_pop_3a = pop;
        c__branch_3a  = br;
        alu__cond_3a  = cond;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        rst_b = 1'b0;
        alu__cond_3a = 0; alu__out_3a = '0; c__branch_3a = '0; c__to_push_3a = '0;
        instruction_3a = '0; pc_3a = '0; r0_3a = '0; r1_3a = '0; st__to_pop_3a = '0;
        repeat (2) @(negedge clk);
        chk("rst_depth", 64'(st__depth_4a), 64'd0);
        chk("rst_top0",  64'(st__top_0_2a), 64'd0);
        chk("rst_kill",  64'(kill_4a), 64'd0);
        chk("rst_fault", 64'(st__fault_4a), 64'd0);
        rst_b = 1'b1;

        // Push imm then alu, pop both
        instruction_3a = {13'd0, 35'h1_0000_0005};
        op(3'd2, 11'd0, 2'd0, 1'b0);
        alu__out_3a = 32'h7;
        op(3'd1, 11'd0, 2'd0, 1'b0);
        chk("pp_depth", 64'(st__depth_4a), 64'd2);
        chk("pp_top0",  64'(st__top_0_2a), 64'h7);
        chk("pp_top1",  64'(st__top_1_2a), 64'h1_0000_0005);
        op(3'd0, 11'd2, 2'd0, 1'b0);
        chk("pop_depth", 64'(st__depth_4a), 64'd0);
        chk("pop_top0",  64'(st__top_0_2a), 64'd0);
        chk("pop_top1",  64'(st__top_1_2a), 64'd0);

        // Dual push
        r0_3a = 35'hA; r1_3a = 35'hB;
        op(3'd5, 11'd0, 2'd0, 1'b0);
        chk("dual_depth", 64'(st__depth_4a), 64'd2);
        chk("dual_top0",  64'(st__top_0_2a), 64'hA);
        chk("dual_top1",  64'(st__top_1_2a), 64'hB);

        // Taken branch with kill window
        instruction_3a = 48'h100;
        op(3'd0, 11'd0, 2'd2, 1'b1);
        chk("br_rv",   64'(redirect_valid_4a), 64'd1);
        chk("br_pc",   64'(redirect_pc_4a), 64'h100);
        chk("br_kill", 64'(kill_4a), 64'd1);
        alu__out_3a = 32'h55;
        op(3'd1, 11'd0, 2'd0, 1'b0);
        chk("k1_kill",  64'(kill_4a), 64'd1);
        chk("k1_rv",    64'(redirect_valid_4a), 64'd0);
        chk("k1_depth", 64'(st__depth_4a), 64'd2);
        op(3'd1, 11'd0, 2'd0, 1'b0);
        chk("k2_kill",  64'(kill_4a), 64'd0);
        chk("k2_depth", 64'(st__depth_4a), 64'd2);
        op(3'd0, 11'd0, 2'd2, 1'b0);
        chk("nt_rv",   64'(redirect_valid_4a), 64'd0);
        chk("nt_kill", 64'(kill_4a), 64'd0);

        // Return-address push with untaken code 3, then taken code 3, reserved push
        pc_3a = 32'h1000;
        op(3'd6, 11'd0, 2'd3, 1'b1);
        chk("ret_top0", 64'(st__top_0_2a), 64'h1006);
        chk("ret_rv",   64'(redirect_valid_4a), 64'd0);
        instruction_3a = 48'h240;
        op(3'd0, 11'd0, 2'd3, 1'b0);
        op(3'd0, 11'd0, 2'd0, 1'b0);
        op(3'd0, 11'd0, 2'd0, 1'b0);
        op(3'd7, 11'd1, 2'd0, 1'b0);
        chk("rsv_depth", 64'(st__depth_4a), 64'd2);
        op(3'd0, 11'd1, 2'd0, 1'b0);

        // Underflow
        chk("uf_pre", 64'(st__depth_4a), 64'd1);
        op(3'd0, 11'd2, 2'd0, 1'b0);
        chk("uf_fault", 64'(st__fault_4a), 64'd1);
        chk("uf_depth", 64'(st__depth_4a), 64'd1);
        op(3'd1, 11'd0, 2'd1, 1'b0);
        chk("uf_ign_depth", 64'(st__depth_4a), 64'd1);
        chk("uf_ign_rv",    64'(redirect_valid_4a), 64'd0);

        // Huge pop on empty stack, then empty with pop 0 is legal
        do_reset();
        op(3'd0, 11'd0, 2'd0, 1'b0);
        chk("empty_ok", 64'(st__fault_4a), 64'd0);
        op(3'd0, 11'd2047, 2'd0, 1'b0);
        chk("bigpop_fault", 64'(st__fault_4a), 64'd1);

        // Overflow from full
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alu__out_3a = 32'(i + 32'h20);
            op(3'd1, 11'd0, 2'd0, 1'b0);
        end
        chk("full_depth", 64'(st__depth_4a), 64'(DEPTH));
        op(3'd0, 11'd0, 2'd0, 1'b0);
        chk("full_idle_fault", 64'(st__fault_4a), 64'd0);
        op(3'd1, 11'd0, 2'd0, 1'b0);
        chk("of_fault", 64'(st__fault_4a), 64'd1);
        chk("of_depth", 64'(st__depth_4a), 64'(DEPTH));

        // Pop one + dual push at DEPTH-1 reaches exactly DEPTH
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            alu__out_3a = 32'(i + 32'h40);
            op(3'd1, 11'd0, 2'd0, 1'b0);
        end
        op(3'd5, 11'd1, 2'd0, 1'b0);
        chk("edge_depth", 64'(st__depth_4a), 64'(DEPTH));
        chk("edge_fault", 64'(st__fault_4a), 64'd0);
        chk("edge_top0",  64'(st__top_0_2a), 64'hA);
        chk("edge_top1",  64'(st__top_1_2a), 64'hB);
        op(3'd4, 11'd0, 2'd0, 1'b0);
        chk("edge_of", 64'(st__fault_4a), 64'd1);

        // Reset during kill window, then a normal branch
        do_reset();
        instruction_3a = 48'h200;
        op(3'd0, 11'd0, 2'd1, 1'b0);
        chk("mk_kill", 64'(kill_4a), 64'd1);
        #2 rst_b = 1'b0;
        #1;
        chk("mk_rst_kill", 64'(kill_4a), 64'd0);
        chk("mk_rst_rv",   64'(redirect_valid_4a), 64'd0);
        chk("mk_rst_pc",   64'(redirect_pc_4a), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        instruction_3a = 48'h300;
        op(3'd0, 11'd0, 2'd1, 1'b0);
        chk("post_rv",   64'(redirect_valid_4a), 64'd1);
        chk("post_pc",   64'(redirect_pc_4a), 64'h300);
        chk("post_kill", 64'(kill_4a), 64'd1);
        op(3'd0, 11'd0, 2'd0, 1'b0);
        op(3'd0, 11'd0, 2'd0, 1'b0);
        chk("post_kill_end", 64'(kill_4a), 64'd0);

        // Return address wraps at 32 bits
        pc_3a = 32'hFFFF_FFFD;
        op(3'd6, 11'd0, 2'd0, 1'b0);
        chk("ret_wrap", 64'(st__top_0_2a), 64'h3);
        op(3'd0, 11'd0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
